gpio_pattern_gen: RTL and testbench

- Output-side counterpart to the GPIO input filter/event path.
- Plays a queued sequence of timed (data, output-enable) patterns onto the GPIO pads, so software can emit exact waveforms without per-edge register writes.
- Sits between the GPIO register file (push side) and the pad drivers (cio_gpio_o / cio_gpio_en_o), muxed with the direct-out path in the top level.

---
 rtl/gpio_pattern_gen_if.sv | 34 +++
 rtl/gpio_pattern_gen.sv | 149 ++++++++++++++
 tb/tb_gpio_pattern_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pattern_gen_if
// Brief    : Push-side handshake bundle between the GPIO register file and
//            the pattern generator FIFO.
// Revision : 1.0
// ============================================================================
interface gpio_pattern_gen_if #(
    parameter int WIDTH     = 32,
    parameter int DUR_WIDTH = 16
);
    logic                 pat_valid;
    logic                 pat_ready;
    logic [WIDTH-1:0]     pat_data;
    logic [WIDTH-1:0]     pat_oe;
    logic [DUR_WIDTH-1:0] pat_dur;

    modport master (
        output pat_valid,
        output pat_data,
        output pat_oe,
        output pat_dur,
        input  pat_ready
    );

    modport slave (
        input  pat_valid,
        input  pat_data,
        input  pat_oe,
        input  pat_dur,
        output pat_ready
    );
endinterface
`default_nettype wire

// File: rtl/gpio_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : gpio_pattern_gen
// Brief    : Plays queued timed (data, output-enable) patterns onto GPIO pads.
//            Optional macro GPIO_PATGEN_LOOP_EN adds loop_i for repeat play.
// Revision : 1.0
// ============================================================================
module gpio_pattern_gen #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int DUR_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       enable_i,
`ifdef GPIO_PATGEN_LOOP_EN
    input  logic                       loop_i,
`endif
    input  logic                       flush_i,
    gpio_pattern_gen_if.slave          pat,
    output logic [WIDTH-1:0]           gpio_o,
    output logic [WIDTH-1:0]           gpio_en_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH + 1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_PLAY = 1'b1;

    logic [WIDTH-1:0]     r_mem_data [DEPTH];
    logic [WIDTH-1:0]     r_mem_oe   [DEPTH];
    logic [DUR_WIDTH-1:0] r_mem_dur  [DEPTH];

    logic [c_AW-1:0]      r_wptr;
    logic [c_AW-1:0]      r_rptr;
    logic [c_LW-1:0]      r_level;
    logic [0:0]           r_state;
    logic [DUR_WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0]     r_gpio;
    logic [WIDTH-1:0]     r_gpio_en;
    logic                 r_done;

    logic                 w_loop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_loop_wr;
    logic                 w_wr;
    logic [WIDTH-1:0]     w_head_data;
    logic [WIDTH-1:0]     w_head_oe;
    logic [DUR_WIDTH-1:0] w_head_dur;
    logic [WIDTH-1:0]     w_wdata;
    logic [WIDTH-1:0]     w_woe;
    logic [DUR_WIDTH-1:0] w_wdur;

`ifdef GPIO_PATGEN_LOOP_EN
    assign w_loop = loop_i;
`else
    assign w_loop = 1'b0;
`endif

    assign w_full        = (r_level == c_LW'(DEPTH));
    assign pat.pat_ready = !w_full && !w_loop;
    assign w_push        = pat.pat_valid && pat.pat_ready && !flush_i;

    // A pop happens from IDLE or on the last cycle of the current entry.
    assign w_pop = enable_i && (r_level != '0) && !flush_i &&
                   ((r_state == c_IDLE) || (r_cnt == '0));

    // In loop mode the popped head is written back at the tail.
    assign w_loop_wr   = w_pop && w_loop;
    assign w_wr        = w_push || w_loop_wr;

    assign w_head_data = r_mem_data[r_rptr];
    assign w_head_oe   = r_mem_oe[r_rptr];
    assign w_head_dur  = r_mem_dur[r_rptr];

    assign w_wdata = w_loop_wr ? w_head_data : pat.pat_data;
    assign w_woe   = w_loop_wr ? w_head_oe   : pat.pat_oe;
    assign w_wdur  = w_loop_wr ? w_head_dur  : pat.pat_dur;

    always_ff @(posedge clk_i) begin
        if (w_wr) begin
            r_mem_data[r_wptr] <= w_wdata;
            r_mem_oe[r_wptr]   <= w_woe;
            r_mem_dur[r_wptr]  <= w_wdur;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_gpio    <= '0;
            r_gpio_en <= '0;
            r_done    <= 1'b0;
        end else if (flush_i) begin
            // Pads keep their current drive; only the queue and FSM clear.
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_wr) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_AW'(1);
            end
            case ({w_push, w_pop && !w_loop})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase

            if (w_pop) begin
                r_gpio    <= w_head_data;
                r_gpio_en <= w_head_oe;
                r_cnt     <= w_head_dur;
                r_state   <= c_PLAY;
            end else if (r_state == c_PLAY) begin
                if (r_cnt != '0) begin
                    r_cnt <= r_cnt - DUR_WIDTH'(1);
                end else begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b1;
                end
            end
        end
    end

    assign gpio_o    = r_gpio;
    assign gpio_en_o = r_gpio_en;
    assign busy_o    = (r_state == c_PLAY);
    assign done_o    = r_done;
    assign level_o   = r_level;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_pattern_gen
// Brief    : Directed self-checking bench for gpio_pattern_gen.
// Revision : 1.0
// ============================================================================
module tb_gpio_pattern_gen;

    localparam int WIDTH     = 32;
    localparam int DEPTH     = 8;
    localparam int DUR_WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic             flush;
`ifdef GPIO_PATGEN_LOOP_EN
    logic             loop;
`endif
    logic [WIDTH-1:0] gpio;
    logic [WIDTH-1:0] gpio_en;
    logic             busy;
    logic             done;
    logic [3:0]       level;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_pattern_gen_if #(.WIDTH(WIDTH), .DUR_WIDTH(DUR_WIDTH)) pif ();

    gpio_pattern_gen #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .DUR_WIDTH (DUR_WIDTH)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .enable_i  (enable),
`ifdef GPIO_PATGEN_LOOP_EN
        .loop_i    (loop),
`endif
        .flush_i   (flush),
        .pat       (pif.slave),
        .gpio_o    (gpio),
        .gpio_en_o (gpio_en),
        .busy_o    (busy),
        .done_o    (done),
        .level_o   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic [31:0] oe, input logic [15:0] dur);
        pif.pat_valid = 1'b1;
        pif.pat_data  = d;
        pif.pat_oe    = oe;
        pif.pat_dur   = dur;
        tick();
        pif.pat_valid = 1'b0;
    endtask

    logic [31:0] seq2 [6] = '{32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd3};

    initial begin
        rst_n         = 1'b0;
        enable        = 1'b0;
        flush         = 1'b0;
`ifdef GPIO_PATGEN_LOOP_EN
        loop          = 1'b0;
`endif
        pif.pat_valid = 1'b0;
        pif.pat_data  = '0;
        pif.pat_oe    = '0;
        pif.pat_dur   = '0;
        tick();
        tick();
        check("rst_gpio",  gpio,    0);
        check("rst_en",    gpio_en, 0);
        check("rst_busy",  busy,    0);
        check("rst_done",  done,    0);
        check("rst_level", level,   0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", pif.pat_ready, 1);

        // Single entry: visible two cycles after the push, held 4 cycles.
        enable = 1'b1;
        push(32'hA5, 32'hFF, 16'd3);
        check("t1_level1", level, 1);
        check("t1_gpio_pre", gpio, 0);
        tick();
        check("t1_gpio", gpio, 32'hA5);
        check("t1_en",   gpio_en, 32'hFF);
        for (int i = 0; i < 4; i++) begin
            check("t1_busy", busy, 1);
            check("t1_nodone", done, 0);
            if (i < 3) tick();
        end
        tick();
        check("t1_idle", busy, 0);
        check("t1_done", done, 1);
        check("t1_hold", gpio, 32'hA5);
        tick();
        check("t1_done_clr", done, 0);
        check("t1_hold2", gpio, 32'hA5);

        // Preloaded back-to-back sequence with mixed durations.
        enable = 1'b0;
        push(32'd1, 32'h1, 16'd0);
        push(32'd2, 32'h1, 16'd1);
        push(32'd3, 32'h1, 16'd2);
        check("t2_level3", level, 3);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("t2_seq", gpio, seq2[i]);
            check("t2_busy", busy, 1);
            check("t2_nodone", done, 0);
        end
        tick();
        check("t2_done", done, 1);
        check("t2_idle", busy, 0);
        check("t2_level0", level, 0);
        check("t2_hold", gpio, 32'd3);
        tick();
        check("t2_done_clr", done, 0);
        enable = 1'b0;

        // Fill past capacity.
        for (int i = 0; i < 9; i++) begin
            check("t3_ready", pif.pat_ready, (i < 8) ? 1 : 0);
            push(32'h10 + i, 32'h0, 16'd0);
        end
        check("t3_level8", level, 8);
        check("t3_full", pif.pat_ready, 0);

        // Enable dropped mid-entry: current entry completes.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_flush_level", level, 0);
        check("t4_flush_done", done, 0);
        push(32'h55, 32'hF, 16'd5);
        push(32'h66, 32'hF, 16'd0);
        push(32'h77, 32'hF, 16'd0);
        enable = 1'b1;
        tick();
        check("t4_level2", level, 2);
        for (int i = 0; i < 6; i++) begin
            check("t4_hold", gpio, 32'h55);
            check("t4_busy", busy, 1);
            tick();
            enable = 1'b0;
        end
        check("t4_idle", busy, 0);
        check("t4_done", done, 1);
        check("t4_level_kept", level, 2);
        check("t4_gpio_kept", gpio, 32'h55);
        tick();
        check("t4_done_clr", done, 0);

        // Flush during play with a simultaneous push.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        push(32'h99, 32'hAA, 16'd7);
        push(32'h01, 32'h0, 16'd0);
        push(32'h02, 32'h0, 16'd0);
        push(32'h03, 32'h0, 16'd0);
        enable = 1'b1;
        tick();
        check("t5_play", gpio, 32'h99);
        check("t5_level3", level, 3);
        flush         = 1'b1;
        pif.pat_valid = 1'b1;
        pif.pat_data  = 32'hEE;
        pif.pat_dur   = 16'd0;
        tick();
        flush         = 1'b0;
        pif.pat_valid = 1'b0;
        check("t5_level0", level, 0);
        check("t5_busy", busy, 0);
        check("t5_nodone", done, 0);
        check("t5_gpio", gpio, 32'h99);
        check("t5_gpio_en", gpio_en, 32'hAA);
        tick();
        check("t5_lost", level, 0);
        check("t5_still_idle", busy, 0);
        check("t5_gpio2", gpio, 32'h99);

        // Reset mid-play; also covers push and pop in the same cycle.
        push(32'hAB, 32'hF0, 16'd5);
        push(32'hCD, 32'h0F, 16'd0);
        check("t6_gpio", gpio, 32'hAB);
        check("t6_level_pp", level, 1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_gpio0", gpio, 0);
        check("t6_en0", gpio_en, 0);
        check("t6_level0", level, 0);
        check("t6_busy0", busy, 0);
        check("t6_done0", done, 0);

`ifdef GPIO_PATGEN_LOOP_EN
        enable = 1'b0;
        push(32'd1, 32'h1, 16'd0);
        push(32'd2, 32'h1, 16'd1);
        loop = 1'b1;
        #1;
        check("t7_ready0", pif.pat_ready, 0);
        enable = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) begin
                tick();
                check("t7_seq", gpio, (i == 0) ? 32'd1 : 32'd2);
                check("t7_level", level, 2);
            end
        end
        loop   = 1'b0;
        enable = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
